// File: rtl/swing_detect_multi.sv
// Per-channel turning-point tracker with hysteresis, swing report at each reversal and low-swing alarm; SWING_TIMEOUT_EN adds a flat-input alarm.
// swing/swing_vld/alarm update one cycle after the causing dat_en; no backpressure, a sample is accepted every cycle.
module swing_detect_multi #(
  parameter int NCH             = 4,
  parameter int DW              = 16,
  parameter int HYST            = 4,
  parameter int ALARM_CNT       = 3,
  parameter int TIMEOUT_SAMPLES = 1000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   detect_enable,
  input  logic [NCH*DW-1:0]      dat,
  input  logic [NCH-1:0]         dat_sign,
  input  logic [NCH-1:0]         dat_en,
  input  logic [DW:0]            swing_thresh,
  output logic [NCH*(DW+1)-1:0]  swing,
  output logic [NCH-1:0]         swing_vld,
  output logic [NCH-1:0]         alarm
);

  localparam int CW = $clog2(ALARM_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ALARM_CNT);
  localparam logic signed [DW+1:0] HYST_S  = (DW+2)'(HYST);
  localparam logic signed [DW+1:0] HYST_S1 = (DW+2)'(HYST + 1);

  typedef enum logic [1:0] {SEED, UNK, RISE, FALL} state_t;

`ifdef SWING_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_SAMPLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_SAMPLES - 1);
`else
  // Without the timeout a constant input can never alarm; the parameter only keeps the interface uniform.
  if (TIMEOUT_SAMPLES < 1) begin : g_timeout_param_unused
  end
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    state_t               state, state_nxt;
    logic [DW-1:0]        mag;
    logic signed [DW+1:0] v_ext, hi, lo;
    logic signed [DW:0]   v, run_max, run_min, peak, valley;
    logic signed [DW:0]   max_nxt, min_nxt, peak_nxt, valley_nxt;
    logic                 rev, low, vld_q;
    logic [DW:0]          swing_new, swing_q;
    logic [CW-1:0]        low_cnt, low_cnt_nxt;

    // Negative zero needs no special case: -0 is 0 in two's complement.
    assign mag   = dat[i*DW +: DW];
    assign v_ext = dat_sign[i] ? -signed'({2'b00, mag}) : signed'({2'b00, mag});
    assign v     = v_ext[DW:0];
    assign hi    = {run_max[DW], run_max};
    assign lo    = {run_min[DW], run_min};

    always_comb begin
      state_nxt  = state;
      max_nxt    = run_max;
      min_nxt    = run_min;
      peak_nxt   = peak;
      valley_nxt = valley;
      rev        = 1'b0;
      if (dat_en[i]) begin
        case (state)
          SEED: begin
            max_nxt   = v;
            min_nxt   = v;
            state_nxt = UNK;
          end
          UNK: begin
            // While undecided the window never exceeds HYST, so a breakout is always a new extreme.
            if (v_ext >= lo + HYST_S1) begin
              valley_nxt = run_min;
              max_nxt    = v;
              state_nxt  = RISE;
            end else if (v_ext <= hi - HYST_S1) begin
              peak_nxt  = run_max;
              min_nxt   = v;
              state_nxt = FALL;
            end else begin
              if (v_ext > hi) max_nxt = v;
              if (v_ext < lo) min_nxt = v;
            end
          end
          RISE: begin
            if (v_ext > hi) begin
              max_nxt = v;
            end else if (v_ext < hi - HYST_S) begin
              peak_nxt  = run_max;
              min_nxt   = v;
              rev       = 1'b1;
              state_nxt = FALL;
            end
          end
          FALL: begin
            if (v_ext < lo) begin
              min_nxt = v;
            end else if (v_ext > lo + HYST_S) begin
              valley_nxt = run_min;
              max_nxt    = v;
              rev        = 1'b1;
              state_nxt  = RISE;
            end
          end
          default: state_nxt = SEED;
        endcase
      end
    end

    // Peak never lies below valley, so the difference fits DW+1 unsigned bits.
    assign swing_new = peak_nxt - valley_nxt;
    assign low       = swing_new < swing_thresh;

    always_comb begin
      low_cnt_nxt = low_cnt;
      if (rev) begin
        if (!low)
          low_cnt_nxt = '0;
        else if (low_cnt != CNT_MAX)
          low_cnt_nxt = low_cnt + 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst || !detect_enable) begin
        state   <= SEED;
        run_max <= '0;
        run_min <= '0;
        peak    <= '0;
        valley  <= '0;
        low_cnt <= '0;
        swing_q <= '0;
        vld_q   <= 1'b0;
      end else begin
        state   <= state_nxt;
        run_max <= max_nxt;
        run_min <= min_nxt;
        peak    <= peak_nxt;
        valley  <= valley_nxt;
        low_cnt <= low_cnt_nxt;
        vld_q   <= rev;
        if (rev) swing_q <= swing_new;
      end
    end

    assign swing[i*(DW+1) +: DW+1] = swing_q;
    assign swing_vld[i]            = vld_q;

`ifdef SWING_TIMEOUT_EN
    logic [TW-1:0] tcnt;
    logic          tflag;

    // A low-swing reversal restarts the count but leaves an existing forced alarm in place.
    always_ff @(posedge clk) begin
      if (rst || !detect_enable) begin
        tcnt  <= '0;
        tflag <= 1'b0;
      end else if (dat_en[i]) begin
        if (rev) begin
          tcnt <= '0;
          if (!low) tflag <= 1'b0;
        end else if (tcnt != TO_MAX) begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == TO_LAST) tflag <= 1'b1;
        end
      end
    end

    assign alarm[i] = (low_cnt == CNT_MAX) | tflag;
`else
    assign alarm[i] = (low_cnt == CNT_MAX);
`endif
  end

endmodule

// File: tb/tb_swing_detect_multi.sv
// Scoreboard bench for swing_detect_multi: directed wave shapes plus random walks against an integer reference model.
module tb_swing_detect_multi;
  localparam int NCH = 4;
  localparam int DW = 16;
  localparam int HYST = 4;
  localparam int ALARM_CNT = 3;
  localparam int TIMEOUT_SAMPLES = 1000;
  localparam int SW = DW + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              detect_enable;
  logic [NCH*DW-1:0] dat;
  logic [NCH-1:0]    dat_sign;
  logic [NCH-1:0]    dat_en;
  logic [DW:0]       swing_thresh;
  logic [NCH*SW-1:0] swing;
  logic [NCH-1:0]    swing_vld;
  logic [NCH-1:0]    alarm;

  always #5 clk = ~clk;

  swing_detect_multi #(
    .NCH(NCH), .DW(DW), .HYST(HYST), .ALARM_CNT(ALARM_CNT), .TIMEOUT_SAMPLES(TIMEOUT_SAMPLES)
  ) dut (
    .clk(clk), .rst(rst), .detect_enable(detect_enable), .dat(dat), .dat_sign(dat_sign),
    .dat_en(dat_en), .swing_thresh(swing_thresh), .swing(swing), .swing_vld(swing_vld), .alarm(alarm)
  );

  typedef struct { logic [NCH-1:0] vld; logic [NCH-1:0] alm; logic [NCH*SW-1:0] sw; } cyc_t;
  typedef struct { int ch; int sw; bit alm; } ev_t;

  cyc_t cyc_q[$];
  ev_t  ev_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: mode 0 = undecided, +1 = rising, -1 = falling.
  bit seeded[NCH];
  int mode[NCH], hi[NCH], lo[NCH], pk[NCH], vl[NCH], lowc[NCH], msw[NCH], tcnt[NCH];
  bit tflag[NCH];
  int cur[NCH], cdir[NCH];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_cycle();
    cyc_t r;
    ev_t  e;
    r.vld = '0;
    r.alm = '0;
    r.sw  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (rst || !detect_enable) begin
        seeded[c] = 0; mode[c] = 0; hi[c] = 0; lo[c] = 0; pk[c] = 0; vl[c] = 0;
        lowc[c] = 0; msw[c] = 0; tcnt[c] = 0; tflag[c] = 0;
      end else if (dat_en[c]) begin
        int v;
        bit rev;
        rev = 0;
        v = int'(dat[c*DW +: DW]);
        if (dat_sign[c]) v = -v;
        if (!seeded[c]) begin
          seeded[c] = 1; hi[c] = v; lo[c] = v;
        end else if (mode[c] == 0) begin
          if (v > hi[c]) hi[c] = v;
          if (v < lo[c]) lo[c] = v;
          if (v >= lo[c] + HYST + 1) begin
            vl[c] = lo[c]; hi[c] = v; mode[c] = 1;
          end else if (v <= hi[c] - HYST - 1) begin
            pk[c] = hi[c]; lo[c] = v; mode[c] = -1;
          end
        end else if (mode[c] == 1) begin
          if (v > hi[c]) hi[c] = v;
          else if (v < hi[c] - HYST) begin
            pk[c] = hi[c]; lo[c] = v; mode[c] = -1; rev = 1;
          end
        end else begin
          if (v < lo[c]) lo[c] = v;
          else if (v > lo[c] + HYST) begin
            vl[c] = lo[c]; hi[c] = v; mode[c] = 1; rev = 1;
          end
        end
        if (rev) begin
          msw[c] = pk[c] - vl[c];
          r.vld[c] = 1'b1;
          if (msw[c] < int'(swing_thresh)) lowc[c] = (lowc[c] < ALARM_CNT) ? lowc[c] + 1 : ALARM_CNT;
          else begin
            lowc[c] = 0; tflag[c] = 0;
          end
          tcnt[c] = 0;
        end else begin
`ifdef SWING_TIMEOUT_EN
          if (tcnt[c] < TIMEOUT_SAMPLES) begin
            tcnt[c]++;
            if (tcnt[c] == TIMEOUT_SAMPLES) tflag[c] = 1;
          end
`endif
        end
      end
      r.alm[c] = (lowc[c] == ALARM_CNT) || tflag[c];
      r.sw[c*SW +: SW] = SW'(msw[c]);
      if (r.vld[c]) begin
        e.ch = c; e.sw = msw[c]; e.alm = r.alm[c];
        ev_q.push_back(e);
      end
    end
    cyc_q.push_back(r);
  endtask

  task automatic step();
    model_cycle();
    @(negedge clk);
  endtask

  task automatic put(input int c, input int val);
    dat[c*DW +: DW] = DW'((val < 0) ? -val : val);
    if (val < 0) dat_sign[c] = 1'b1;
    else if (val == 0) dat_sign[c] = 1'($urandom_range(0, 1));
    else dat_sign[c] = 1'b0;
  endtask

  task automatic fill_random();
    for (int k = 0; k < NCH; k++) put(k, int'($urandom_range(0, 2000)) - 1000);
  endtask

  task automatic sample(input int c, input int val, input int th);
    fill_random();
    dat_en = '0;
    dat_en[c] = 1'b1;
    put(c, val);
    swing_thresh = SW'(th);
    step();
    if ($urandom_range(0, 3) == 0) begin
      dat_en = '0;
      step();
    end
  endtask

  task automatic ramp(input int c, input int from, input int to, input int stp, input int th);
    int v = from;
    for (int n = 0; n < 1000; n++) begin
      sample(c, v, th);
      if (v == to) break;
      v += (to > from) ? stp : -stp;
    end
  endtask

  initial begin : monitor
    cyc_t r;
    ev_t  e;
    forever begin
      @(posedge clk);
      #1;
      if (cyc_q.size() > 0) begin
        r = cyc_q.pop_front();
        chk("swing_vld", 128'(swing_vld), 128'(r.vld));
        chk("alarm", 128'(alarm), 128'(r.alm));
        chk("swing", 128'(swing), 128'(r.sw));
      end
      for (int c = 0; c < NCH; c++) begin
        if (swing_vld[c] === 1'b1) begin
          if (ev_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_swing_vld ch=%0d got=1 exp=0", c);
          end else begin
            e = ev_q.pop_front();
            chk("ev_channel", 128'(c), 128'(e.ch));
            chk("ev_swing", 128'(swing[c*SW +: SW]), 128'(e.sw));
            chk("ev_alarm", 128'(alarm[c]), 128'(e.alm));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog t=%0t got=running exp=finished", $time);
    $fatal(1, "bench timeout");
  end

  initial begin : driver
    int noise [4] = '{0, 3, -1, 2};
    rst = 1'b1; detect_enable = 1'b1; dat = '0; dat_sign = '0; dat_en = '0; swing_thresh = '0;
    for (int c = 0; c < NCH; c++) begin cur[c] = 0; cdir[c] = 1; end
    @(negedge clk);

    repeat (2) begin
      fill_random();
      dat_en = NCH'($urandom);
      step();
    end
    rst = 1'b0;
    dat_en = '0;
    step();

    ramp(0, 0, 100, 10, 50);
    ramp(0, 90, -100, 10, 50);
    ramp(0, -90, 100, 10, 50);

    ramp(1, 0, 10, 5, 50);
    ramp(1, 5, -10, 5, 50);
    ramp(1, -5, 10, 5, 50);
    ramp(1, 5, 0, 5, 50);
    chk("alarm1_after_3_small", 128'(alarm[1]), 128'(1));
    ramp(1, -5, -100, 5, 50);
    ramp(1, -95, 100, 5, 50);
    chk("alarm1_after_recovery", 128'(alarm[1]), 128'(0));

    repeat (10) for (int k = 0; k < 4; k++) sample(2, noise[k], 50);

    ramp(1, 95, -10, 5, 50);
    repeat (3) begin
      ramp(1, -5, 10, 5, 50);
      ramp(1, 5, -10, 5, 50);
    end
    chk("alarm1_before_disable", 128'(alarm[1]), 128'(1));
    detect_enable = 1'b0;
    dat_en = NCH'($urandom);
    step();
    detect_enable = 1'b1;
    dat_en = '0;
    chk("alarm1_after_disable", 128'(alarm[1]), 128'(0));
    ramp(1, 0, 10, 5, 50);
    ramp(1, 5, -10, 5, 50);
    chk("alarm1_one_fresh_reversal", 128'(alarm[1]), 128'(0));
    ramp(1, 0, 10, 5, 50);
    ramp(1, 5, -10, 5, 50);
    chk("alarm1_three_fresh_reversals", 128'(alarm[1]), 128'(1));

    for (int n = 0; n < 60; n++) begin
      dat_en = '1;
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 5) == 0) cdir[c] = -cdir[c];
        cur[c] += cdir[c] * int'($urandom_range(1, 15));
        put(c, cur[c]);
      end
      swing_thresh = SW'($urandom_range(0, 60));
      step();
    end

    detect_enable = 1'b0;
    step();
    detect_enable = 1'b1;
    swing_thresh = SW'(50);
    for (int n = 0; n < 1000; n++) begin
      fill_random();
      dat_en = NCH'(1) << 3;
      put(3, -500);
      step();
    end
`ifdef SWING_TIMEOUT_EN
    chk("alarm3_flat_timeout", 128'(alarm[3]), 128'(1));
`else
    chk("alarm3_flat_no_timeout", 128'(alarm[3]), 128'(0));
`endif

    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      detect_enable = ($urandom_range(0, 99) != 0);
      for (int c = 0; c < NCH; c++) begin
        dat_en[c] = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) cdir[c] = -cdir[c];
        if ($urandom_range(0, 49) == 0) cur[c] = 0;
        else cur[c] += cdir[c] * int'($urandom_range(0, 25));
        if (cur[c] > 60000) cur[c] = 60000;
        if (cur[c] < -60000) cur[c] = -60000;
        put(c, cur[c]);
      end
      swing_thresh = SW'($urandom_range(0, 300));
      step();
    end

    rst = 1'b0;
    detect_enable = 1'b1;
    dat_en = '0;
    step();
    for (int n = 0; n < 20 && cyc_q.size() > 0; n++) @(posedge clk);
    #2;
    chk("scoreboard_drained", 128'(cyc_q.size()), 128'(0));
    chk("events_drained", 128'(ev_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swing_detect_multi.md
Name: swing_detect_multi

Overview:
Parametrised successor to the fixed 4-channel zero-swing detector. It merges the peak/valley search and the alarm generation into one block. Each of NCH sign-magnitude channels gets a per-channel turning-point tracker with hysteresis, and a per-cycle swing measurement (peak minus valley) is reported at every direction reversal. A channel raises its alarm after ALARM_CNT consecutive half-cycles whose swing is below a runtime threshold.

Parameters:
NCH, 4, number of channels
DW, 16, magnitude width per channel
HYST, 4, reversal hysteresis in LSBs (unsigned, less than 2^DW)
ALARM_CNT, 3, consecutive low-swing half-cycles needed to assert alarm (at least 1)
TIMEOUT_SAMPLES, 1000, enabled samples with no reversal before timeout alarm (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
detect_enable  in  1  global enable; low synchronously clears all channel state
dat  in  NCH*DW  magnitudes, channel i at [i*DW +: DW]
dat_sign  in  NCH  per-channel sign, 1 = negative
dat_en  in  NCH  per-channel sample strobe, 1-cycle pulses
swing_thresh  in  DW+1  unsigned minimum acceptable swing, sampled at each reversal
swing  out  NCH*(DW+1)  last measured swing, channel i at [i*(DW+1) +: DW+1]
swing_vld  out  NCH  1-cycle pulse when that channel's swing updates
alarm  out  NCH  per-channel level alarm

Behaviour:
- Reset (rst=1) or detect_enable=0 at a clock edge:
  - all outputs go to 0
  - every channel goes to SEED, and its low-swing counter is cleared.
  - rst has priority over everything else.
- Sample conversion: v = dat_sign ? -mag : mag, as a (DW+1)-bit signed value. Negative zero (sign=1, mag=0) is treated as 0.
- All comparisons are done in DW+2 signed bits, so no overflow is possible.
- Channels are fully independent. They advance only on their own dat_en while detect_enable=1. Simultaneous strobes on several channels are all processed in the same cycle.
- Per-channel FSM (run_max, run_min, peak and valley are registers):
  - SEED: on first sample, run_max = run_min = v, go to UNK.
  - UNK:
    - update run_max and run_min with v.
    - if v >= run_min+HYST+1: valley = run_min, run_max = v, go to RISE.
    - else if v <= run_max-HYST-1: peak = run_max, run_min = v, go to FALL.
    - Rising is checked first.
  - RISE:
    - if v > run_max, run_max = v.
    - else if v < run_max-HYST: peak = run_max, run_min = v, REVERSAL, go to FALL.
  - FALL:
    - if v < run_min, run_min = v.
    - else if v > run_min+HYST: valley = run_min, run_max = v, REVERSAL, go to RISE.
- On REVERSAL:
  - swing = peak - valley, unsigned DW+1 bits, using the just-updated extreme.
  - swing_vld pulses on the cycle after the causing dat_en; swing is registered on the same edge.
- Alarm, updated on the same edge as swing_vld:
  - if swing < swing_thresh: low counter increments, saturating at ALARM_CNT.
  - otherwise: low counter = 0 and alarm deasserts.
  - alarm = 1 while low counter == ALARM_CNT.
- Samples equal to the running extreme, or within HYST of it, cause no state change.
- swing holds its value between pulses. swing_vld never fires in SEED or UNK.

Optional Feature:
SWING_TIMEOUT_EN
- Defined:
  - each channel has a saturating enabled-sample counter, reset at every REVERSAL and on SEED entry.
  - when the counter reaches TIMEOUT_SAMPLES, alarm is forced to 1, covering a signal stuck flat that never produces a reversal.
  - the forced alarm clears on the next REVERSAL with swing >= swing_thresh.
- Undefined: no counter exists, and a constant input never raises an alarm.

Test Plan:
1. Reset behaviour: rst=1 for 2 cycles, with random dat and dat_en toggling -> alarm=0, swing_vld=0, swing=0 on all channels.
2. Large triangle wave on ch0: ch0 samples in steps of 10, going 0 -> +100 -> -100 -> +100, swing_thresh=50.
   - swing_vld[0] pulses with swing=100, then 200.
   - alarm[0] stays 0.
   - channels 1-3 stay silent.
3. Small triangle, then recovery, on ch1: ch1 triangle ±10 in steps of 5, swing_thresh=50.
   - First three reversals give swing values 10, 20, 20; alarm[1] rises with the 3rd swing_vld.
   - Switch to ±100: the next reversal gives swing=110 and alarm[1] clears in the same cycle.
4. Hysteresis noise on ch2: ch2 alternating 0, +3, -1, +2, with HYST=4 -> no swing_vld[2] ever, and the FSM stays in UNK.
5. Disable mid-alarm, then simultaneous strobes:
   - With alarm[1]=1, drop detect_enable for 1 cycle -> alarm[1]=0 next cycle, and a new ±10 pattern needs 3 fresh reversals to re-alarm.
   - All four channels strobed in the same cycle are each processed correctly.
6. Flat input on ch3: constant ch3 = -500 (sign=1, mag=500) for 1000 enabled samples.
   - With SWING_TIMEOUT_EN: alarm[3]=1 after the 1000th sample.
   - Without it: alarm[3] stays 0.
